// File: rtl/window_pkg.sv
// Shared types and window geometry for the 3x3 streaming window generator.
package window_pkg;

  typedef enum logic [1:0] {
    WAIT_SOF,
    FIRST_ROW,
    STREAM,
    DRAIN_ERR
  } state_t;

  localparam int WIN_ROWS = 3;
  localparam int WIN_COLS = 3;
  localparam int WIN_TAPS = WIN_ROWS * WIN_COLS;

  // Flat tap index of window element (r,c); r=0 is the oldest row.
  function automatic int win_idx(input int r, input int c);
    return WIN_COLS * r + c;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage: synchronous write, asynchronous read at the same column.
module line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read-before-write: the old row value is seen in the same cycle it is replaced.
  assign rdata = mem[addr];

endmodule

// File: rtl/axis_window_3x3.sv
// AXI-Stream 3x3 sliding-window generator: measures row length from the first
// row of each frame and emits one valid-convolution window per interior pixel.
module axis_window_3x3
  import window_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int S_TDATA_WIDTH = 32,
  parameter int MAX_COLS      = 64
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic [S_TDATA_WIDTH-1:0]       s_axis_tdata,
  input  logic                           s_axis_tlast,
  input  logic                           s_axis_tuser,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [WIN_TAPS*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tuser,
  output logic                           frame_err
);

  localparam int CW = $clog2(MAX_COLS + 1);
  localparam int AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;

  state_t                        state, state_n;
  logic [CW-1:0]                 col, col_n, cols, cols_n, pcol;
  logic [1:0]                    row, row_n;
  logic                          run, slot_free, accept, is_sof, active;
  logic                          err, emit, last_col, win_last, win_user;
  logic [DATA_WIDTH-1:0]         pixel, top_px, mid_px;
  logic [DATA_WIDTH-1:0]         cur [WIN_ROWS];
  logic [DATA_WIDTH-1:0]         sh0 [WIN_ROWS];
  logic [DATA_WIDTH-1:0]         sh1 [WIN_ROWS];
  logic [WIN_TAPS*DATA_WIDTH-1:0] win;
  logic                          unused_tdata;

  assign pixel        = s_axis_tdata[DATA_WIDTH-1:0];
  assign unused_tdata = ^s_axis_tdata;
  assign slot_free    = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = run && slot_free;
  assign accept       = s_axis_tvalid && s_axis_tready;
  assign is_sof       = accept && s_axis_tuser;
  assign active       = accept && (is_sof || state == FIRST_ROW || state == STREAM);
  assign pcol         = is_sof ? '0 : col;

  // Row counter saturates at 3: >=2 means window rows, ==2 marks the first window row.
  always_comb begin
    state_n  = state;
    col_n    = col;
    cols_n   = cols;
    row_n    = row;
    err      = 1'b0;
    emit     = 1'b0;
    last_col = 1'b0;
    win_last = 1'b0;
    win_user = 1'b0;
    if (is_sof || (accept && state == FIRST_ROW)) begin
      if (s_axis_tlast) begin
        if (pcol < CW'(2)) begin
          err = 1'b1;
        end else begin
          cols_n  = pcol + CW'(1);
          col_n   = '0;
          row_n   = 2'd1;
          state_n = STREAM;
        end
      end else if (pcol == CW'(MAX_COLS - 1)) begin
        err = 1'b1;
      end else begin
        col_n   = pcol + CW'(1);
        row_n   = 2'd0;
        state_n = FIRST_ROW;
      end
    end else if (accept && state == STREAM) begin
      last_col = (col == cols - CW'(1));
      if (s_axis_tlast != last_col) begin
        err = 1'b1;
      end else begin
        emit     = row[1] && (col >= CW'(2));
        win_last = last_col;
        win_user = (row == 2'd2) && (col == CW'(2));
        if (s_axis_tlast) begin
          col_n = '0;
          row_n = (row == 2'd3) ? row : row + 2'd1;
        end else begin
          col_n = col + CW'(1);
        end
      end
    end
    if (err) state_n = DRAIN_ERR;
  end

  line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MAX_COLS), .AW(AW)) u_lb_old (
    .clk   (clk),
    .we    (active),
    .addr  (pcol[AW-1:0]),
    .wdata (mid_px),
    .rdata (top_px)
  );

  line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MAX_COLS), .AW(AW)) u_lb_new (
    .clk   (clk),
    .we    (active),
    .addr  (pcol[AW-1:0]),
    .wdata (pixel),
    .rdata (mid_px)
  );

  always_comb begin
    cur[0] = top_px;
    cur[1] = mid_px;
    cur[2] = pixel;
    win    = '0;
    for (int r = 0; r < WIN_ROWS; r++) begin
      win[DATA_WIDTH*win_idx(r, 0) +: DATA_WIDTH] = sh0[r];
      win[DATA_WIDTH*win_idx(r, 1) +: DATA_WIDTH] = sh1[r];
      win[DATA_WIDTH*win_idx(r, 2) +: DATA_WIDTH] = cur[r];
    end
  end

  always_ff @(posedge clk) begin
    if (active) begin
      for (int r = 0; r < WIN_ROWS; r++) begin
        sh0[r] <= sh1[r];
        sh1[r] <= cur[r];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run           <= 1'b0;
      state         <= WAIT_SOF;
      col           <= '0;
      cols          <= '0;
      row           <= '0;
      frame_err     <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else begin
      run       <= 1'b1;
      state     <= state_n;
      col       <= col_n;
      cols      <= cols_n;
      row       <= row_n;
      frame_err <= err;
      if (slot_free) begin
        m_axis_tvalid <= emit;
        if (emit) begin
          m_axis_tdata <= win;
          m_axis_tlast <= win_last;
          m_axis_tuser <= win_user;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_window_3x3.sv
// Directed scoreboard bench for axis_window_3x3: expected windows are queued as
// pixels are driven and popped as the DUT hands windows downstream.
module tb_axis_window_3x3;

  localparam int DW = 8;
  localparam int SW = 32;
  localparam int MC = 64;

  typedef struct packed {
    logic [9*DW-1:0] data;
    logic            last;
    logic            user;
  } win_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic [SW-1:0]   s_axis_tdata;
  logic            s_axis_tlast;
  logic            s_axis_tuser;
  logic            m_axis_tvalid;
  logic            m_axis_tready = 1'b1;
  logic [9*DW-1:0] m_axis_tdata;
  logic            m_axis_tlast;
  logic            m_axis_tuser;
  logic            frame_err;

  int   vectors = 0;
  int   fails   = 0;
  int   err_cnt = 0;
  int   rmode   = 0;
  bit   rand_valid = 1'b0;
  win_t exp_q[$];
  win_t got_q[$];

  always #5 clk = ~clk;

  axis_window_3x3 #(.DATA_WIDTH(DW), .S_TDATA_WIDTH(SW), .MAX_COLS(MC)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .frame_err     (frame_err)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Downstream ready: 0 = always ready, 1 = toggle every cycle, 2 = hold off.
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ~m_axis_tready;
      default: m_axis_tready = 1'b0;
    endcase
  end

  logic prev_stall = 1'b0;
  logic prev_err   = 1'b0;
  win_t prev_out;
  win_t e;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
      prev_err   = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_stable", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser}, {1'b1, prev_out});
      if (frame_err) begin
        err_cnt++;
        check("err_one_cycle", prev_err, 1'b0);
      end
      prev_err = frame_err;
      if (m_axis_tvalid && m_axis_tready) begin
        check("win_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("win_data", m_axis_tdata, e.data);
          check("win_last", m_axis_tlast, e.last);
          check("win_user", m_axis_tuser, e.user);
        end
        got_q.push_back({m_axis_tdata, m_axis_tlast, m_axis_tuser});
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_out   = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
    end
  end

  task automatic send_px(input int v, input bit last, input bit user);
    int guard;
    bit acc;
    if (rand_valid) begin
      while ($urandom_range(0, 1) == 0) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
      end
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = {24'hA5A5A5, 8'(v)};
    s_axis_tlast  = last;
    s_axis_tuser  = user;
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 100) begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk); #1;
      guard++;
    end
    check("px_accepted", acc, 1'b1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic send_frame(input int rows, input int cols, input int base);
    int   pix [8][8];
    win_t w;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        pix[r][c] = (base + r * cols + c) % 256;
        if (r >= 2 && c >= 2) begin
          w = '0;
          for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
              w.data[DW*(3*dr+dc) +: DW] = 8'(pix[r-2+dr][c-2+dc]);
          w.last = (c == cols - 1);
          w.user = (r == 2 && c == 2);
          exp_q.push_back(w);
        end
        send_px(pix[r][c], c == cols - 1, r == 0 && c == 0);
      end
    end
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  task automatic check_5x5(input string tag, input logic [9*DW-1:0] first, input logic [9*DW-1:0] lastw);
    logic [8:0] tl, tu;
    tl = '0;
    tu = '0;
    for (int i = 0; i < 9 && i < got_q.size(); i++) begin
      tl[i] = got_q[i].last;
      tu[i] = got_q[i].user;
    end
    check({tag, "_count"}, got_q.size(), 9);
    check({tag, "_first"}, got_q[0].data, first);
    check({tag, "_lastwin"}, got_q[8].data, lastw);
    check({tag, "_tlast"}, tl, 9'b100100100);
    check({tag, "_tuser"}, tu, 9'b000000001);
  endtask

  int e0;
  logic [9*DW-1:0] w_first, w_last;

  initial begin
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    reset_n       = 1'b0;
    w_first = {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0};
    w_last  = {8'd24, 8'd23, 8'd22, 8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, frame_err}, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 5x5 frame, full throughput
    got_q.delete(); e0 = err_cnt;
    send_frame(5, 5, 0);
    wait_drain();
    check_5x5("t1", w_first, w_last);
    check("t1_err", err_cnt - e0, 0);

    // Same frame with toggling ready and random valid gaps
    got_q.delete(); e0 = err_cnt;
    rmode = 1; rand_valid = 1'b1;
    send_frame(5, 5, 0);
    wait_drain();
    rmode = 0; rand_valid = 1'b0;
    check_5x5("t2", w_first, w_last);
    check("t2_err", err_cnt - e0, 0);

    // 4-pixel first row, then tlast at col 2; later pixels are discarded
    got_q.delete(); e0 = err_cnt;
    send_px(1, 0, 1); send_px(2, 0, 0); send_px(3, 0, 0); send_px(4, 1, 0);
    send_px(5, 0, 0); send_px(6, 0, 0); send_px(7, 1, 0);
    for (int i = 0; i < 12; i++) send_px(40 + i, (i % 4) == 3, 0);
    repeat (4) @(posedge clk); #1;
    check("t3_err_pulses", err_cnt - e0, 1);
    check("t3_no_windows", got_q.size(), 0);
    send_frame(5, 5, 100);
    wait_drain();
    check("t3_recover_count", got_q.size(), 9);
    check("t3_recover_err", err_cnt - e0, 1);

    // Row length 2
    got_q.delete(); e0 = err_cnt;
    send_px(1, 0, 1); send_px(2, 1, 0);
    for (int i = 0; i < 12; i++) send_px(60 + i, (i % 4) == 3, 0);
    repeat (4) @(posedge clk); #1;
    check("t4_err_pulses", err_cnt - e0, 1);
    check("t4_no_windows", got_q.size(), 0);

    // New SOF at row 3 of a 6-wide frame
    got_q.delete(); e0 = err_cnt;
    send_frame(3, 6, 50);
    send_frame(5, 5, 150);
    wait_drain();
    check("t5_count", got_q.size(), 13);
    check("t5_new_tuser", got_q[4].user, 1'b1);
    check("t5_new_first", got_q[4].data, {8'd162, 8'd161, 8'd160, 8'd157, 8'd156, 8'd155, 8'd152, 8'd151, 8'd150});
    check("t5_err", err_cnt - e0, 0);

    // Reset mid-frame with a window held in the output slot
    got_q.delete();
    rmode = 2;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5 && !(r == 2 && c == 3); c++)
        send_px(200 + 5 * r + c, c == 4, r == 0 && c == 0);
    @(negedge clk);
    check("t6_pending", {m_axis_tvalid, s_axis_tready}, 2'b10);
    @(posedge clk); #1;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t6_reset_outputs", {s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, frame_err}, 0);
    end
    rmode = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    e0 = err_cnt;
    for (int i = 0; i < 10; i++) send_px(90 + i, (i % 5) == 4, 0);
    send_frame(5, 5, 0);
    wait_drain();
    check_5x5("t6", w_first, w_last);
    check("t6_err", err_cnt - e0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: observed no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axis_window_3x3.md
AXIS_WINDOW_3X3 -- requirements
Module: axis_window_3x3

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: pixel width, taken from s_axis_tdata[DATA_WIDTH-1:0].
REQ-002 SHALL have parameter S_TDATA_WIDTH, default 32: input tdata width; bits above DATA_WIDTH ignored.
REQ-003 SHALL have parameter MAX_COLS, default 64: largest supported row length in pixels (single channel).
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 s_axis_tvalid  in  1  input pixel valid.
REQ-007 s_axis_tready  out  1  input accept.
REQ-008 s_axis_tdata  in  S_TDATA_WIDTH  input pixel.
REQ-009 s_axis_tlast  in  1  last pixel of row.
REQ-010 s_axis_tuser  in  1  first pixel of frame (SOF).
REQ-011 m_axis_tvalid  out  1  window valid.
REQ-012 m_axis_tready  in  1  downstream accept.
REQ-013 m_axis_tdata  out  9*DATA_WIDTH  3x3 window; element (r,c) at [DATA_WIDTH*(3r+c) +: DATA_WIDTH], r=0 oldest row, c=0 leftmost column.
REQ-014 m_axis_tlast  out  1  last window of an output row.
REQ-015 m_axis_tuser  out  1  first window of a frame.
REQ-016 frame_err  out  1  one-cycle pulse on framing error.

Function
REQ-017 Input transfer SHALL occur when s_axis_tvalid && s_axis_tready; output transfer when m_axis_tvalid && m_axis_tready.
REQ-018 s_axis_tready SHALL equal (state != RESET-held) && (!m_axis_tvalid || m_axis_tready): single registered output slot, no bubble at full throughput.
REQ-019 Output held (tvalid, tdata, tlast, tuser) SHALL remain stable while m_axis_tvalid && !m_axis_tready.
REQ-020 FSM states: WAIT_SOF, FIRST_ROW, STREAM, DRAIN_ERR.
REQ-021 WAIT_SOF: pixels without tuser SHALL be accepted and discarded; pixel with tuser -> FIRST_ROW, col=0, row=0.
REQ-022 FIRST_ROW: row length SHALL be measured; tlast sets cols=col+1 and -> STREAM, row=1.
REQ-023 STREAM: tlast at col==cols-1 SHALL advance row, col=0; tlast at any other col, or col reaching cols without tlast, SHALL pulse frame_err and -> DRAIN_ERR.
REQ-024 Row length <3 or >MAX_COLS SHALL pulse frame_err and -> DRAIN_ERR.
REQ-025 DRAIN_ERR: input SHALL be discarded until tuser pixel, which restarts as in REQ-021.
REQ-026 tuser accepted in FIRST_ROW or STREAM SHALL start a new frame (row=0, col=0, cols re-measured) with no frame_err.
REQ-027 Frames SHALL be unbounded in height; end of frame is implied by next SOF.
REQ-028 Window SHALL be emitted (valid convolution, no padding) for each accepted pixel with row>=2 and col>=2; per frame (rows-2)*(cols-2) windows.
REQ-029 Latency: window completed by pixel accepted in cycle N SHALL present m_axis_tvalid in cycle N+1.
REQ-030 m_axis_tuser SHALL be 1 only for window at row==2, col==2; m_axis_tlast 1 only for col==cols-1.
REQ-031 Two line buffers SHALL hold rows row-1 and row-2, written at col on every accepted pixel in FIRST_ROW/STREAM; 3-column shift registers per row form the window.

Reset
REQ-032 On reset_n low: state=WAIT_SOF, row=col=cols=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, frame_err=0, s_axis_tready=0 while reset asserted.
REQ-033 Line buffer contents SHALL NOT require reset; reset mid-frame SHALL discard the partial frame and any pending window.

Structure
REQ-034 Package window_pkg SHALL hold the state_t enum and window-index helper constants.
REQ-035 Sub-module line_buffer (depth MAX_COLS, width DATA_WIDTH, single write/async-read or 1-cycle read aligned to the shift register) SHALL be instantiated twice.

Verification
REQ-036 5x5 frame, pixel=5r+c, m_axis_tready=1 -> 9 windows; first = {0,1,2,5,6,7,10,11,12} with tuser=1; tlast on windows 3,6,9; last = {12,13,14,17,18,19,22,23,24}.
REQ-037 Same frame, m_axis_tready toggling 1/0 each cycle, s_axis_tvalid random -> identical 9 windows, no loss/duplication, output stable while stalled.
REQ-038 4-pixel first row then row with tlast at col 2 -> frame_err pulse one cycle, no further windows until next tuser; following 5x5 frame correct.
REQ-039 Row length 2 (tlast on second pixel) -> frame_err, zero windows.
REQ-040 tuser asserted at row 3 of 6x6 frame -> new frame starts cleanly, first window of new frame has tuser=1, no frame_err.
REQ-041 reset_n low for 2 cycles mid-frame -> all outputs 0, s_axis_tready=0 during reset; pixels before next tuser discarded.
